pmem_line_responder: RTL
========================

// Module: pmem_line_responder
// PURPOSE
//  Memory-side responder for the cache's 256-bit physical-memory line interface.
//  Accepts one line read or line write at a time and returns pmem_resp after a
//  fixed latency. Reads return a full line from an internal backing store.
//  Sits below the cache as a synthesizable main-memory model for bring-up and
//  for cache verification.
// PARAMETERS
//  s_offset   5    line offset bits; line = 2**s_offset bytes
//  s_line     256  line width in bits (= 8*2**s_offset)
//  s_depth    6    backing-store index bits; store holds 2**s_depth lines
//  LATENCY    4    cycles from request accept to pmem_resp; legal range >= 1
// PORTS
//  clk          in   1       clock; all logic updates on the rising edge
//  rst          in   1       synchronous reset, active-low (0 = reset)
//  pmem_address in   32      line address from the cache; bits [s_offset-1:0] ignored
//  pmem_read    in   1       line read request
//  pmem_write   in   1       line write request
//  pmem_wdata   in   s_line  write line, whole line written
//  pmem_rdata   out  s_line  read line; valid in the cycle pmem_resp=1 for a read
//  pmem_resp    out  1       one-cycle completion pulse
//  busy         out  1       1 while a transaction is outstanding (BUSY or RESP)
//  proto_err    out  1       sticky: read and write seen high together at accept
// BEHAVIOUR
//  Reset (rst=0 at an edge)
//   - state=IDLE; pmem_resp=0, pmem_rdata=0, busy=0, proto_err=0, counter=0.
//   - Backing-store contents are not reset.
//   - An in-flight transaction is dropped: no resp is issued and no store write occurs.
//  Indexing
//   - idx = pmem_address[s_offset+s_depth-1 : s_offset].
//   - Higher address bits are ignored, so addresses alias modulo 2**(s_offset+s_depth).
//  FSM: IDLE -> BUSY -> RESP -> IDLE
//   - IDLE: if pmem_read|pmem_write, accept the request in that cycle (t0).
//     Latch idx, op and pmem_wdata, load cnt=LATENCY-1, and go to BUSY.
//     If LATENCY=1, go straight to RESP.
//   - BUSY: decrement cnt; go to RESP when cnt reaches 0.
//     Inputs are ignored here; the latched values are used.
//   - RESP: pmem_resp=1 for exactly this cycle (t0+LATENCY), then go to IDLE.
//     Read: pmem_rdata = store[latched idx].
//     Write: store[latched idx] <= latched wdata at the end of this cycle.
//  Handshake rules
//   - The initiator holds its request until it sees resp.
//   - A request still high in the cycle after RESP is accepted as a new transaction.
//     Back-to-back responses are therefore spaced LATENCY+1 cycles apart.
//  pmem_rdata
//   - Holds the last read line.
//   - Not updated by writes or in non-RESP cycles.
//  Simultaneous pmem_read & pmem_write at accept
//   - proto_err<=1 (sticky until reset).
//   - The transaction is executed as a write.
//  Read-after-write to the same idx
//   - Returns the new data, because the write commits in the RESP cycle before
//     the next accept.
//  busy = (state != IDLE).
// TESTING
//  1. Write 0xA5..A5 line to 0x0000_0040, LATENCY=4
//     -> resp at t0+4 only; a following read of 0x40 returns 0xA5..A5 at its t0+4.
//  2. Read 0x0000_005F after test 1
//     -> returns the same line as 0x40 (offset ignored); pmem_resp high for exactly 1 cycle.
//  3. Read 0x1000_0040 (s_depth=6)
//     -> aliases to idx 2 and returns 0xA5..A5.
//  4. Hold pmem_read high continuously from t0
//     -> resp at t0+4 and t0+9; busy=0 only at t0+5.
//  5. Assert read and write together with wdata=0x1234..
//     -> proto_err=1 and stays 1; a later read returns 0x1234..
//  6. Start a write to 0x80, pull rst=0 at t0+2
//     -> no resp; all outputs 0; a subsequent read of 0x80 returns the old contents.

Source files
------------

// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//   Main-memory model that answers the cache's 256-bit line interface. It
//   accepts one line read or line write at a time and returns a one-cycle
//   pmem_resp a fixed LATENCY cycles after the accept. Lines live in an
//   internal store of 2**s_depth entries that is indexed by the line address
//   and is not cleared by reset.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-low
//   pmem_address in   line address; offset bits and bits above the index are ignored
//   pmem_read    in   line read request, held until pmem_resp
//   pmem_write   in   line write request, held until pmem_resp
//   pmem_wdata   in   full write line
//   pmem_rdata   out  last line read; it changes only when a read response starts
//   pmem_resp    out  one-cycle completion pulse
//   busy         out  high while a transaction is outstanding
//   proto_err    out  sticky flag: read and write were both high at an accept

module pmem_line_responder #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_depth  = 6,
    parameter int LATENCY  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              busy,
    output logic              proto_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    // Values captured at accept. The inputs are ignored until the next accept.
    logic [s_depth-1:0] idx_q;
    logic               wr_q;
    logic [s_line-1:0]  wdata_q;

    logic [s_line-1:0]  store [0:(2**s_depth)-1];

    logic [s_depth-1:0] req_idx;
    logic [s_depth-1:0] rd_idx;
    logic               rd_is_read;
    logic               load_rdata;
    logic               addr_unused;

    assign req_idx     = pmem_address[s_offset+s_depth-1:s_offset];
    assign addr_unused = ^{pmem_address[31:s_offset+s_depth], pmem_address[s_offset-1:0]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // The counter is loaded with LATENCY-1. Leaving on the cycle
                // where it steps from 1 to 0 gives LATENCY-1 BUSY cycles.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The read line has to be valid during the RESP cycle, so it is loaded on
    // the edge that enters RESP. With LATENCY=1 that edge leaves IDLE, and the
    // request is then still on the inputs rather than in the captured values.
    // A write to the same line commits at the end of an earlier RESP cycle, so
    // a following read always sees it.
    always_comb begin
        rd_idx     = idx_q;
        rd_is_read = !wr_q;
        if (state_q == IDLE) begin
            rd_idx     = req_idx;
            rd_is_read = !pmem_write;
        end
        load_rdata = (state_d == RESP) && (state_q != RESP) && rd_is_read;
    end

    // Control state and outputs that reset clears
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pmem_rdata <= '0;
            proto_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_rdata) begin
                pmem_rdata <= store[rd_idx];
            end
            if (accept && pmem_read && pmem_write) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Request capture. A simultaneous read and write is carried out as a write.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            wr_q    <= pmem_write;
            wdata_q <= pmem_wdata;
        end
    end

    // The store is committed at the end of RESP. A reset that lands during a
    // transaction also stops the write.
    always_ff @(posedge clk) begin
        if (rst && (state_q == RESP) && wr_q) begin
            store[idx_q] <= wdata_q;
        end
    end

    assign pmem_resp = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule
